// File: rtl/sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sram_fifo_ctrl
//
// Ready/valid FIFO controller that sequences an external dual-port SRAM with
// a fixed read latency. Producer words go straight into the SRAM. Reads are
// issued ahead of demand as long as read credits remain. Returning read data
// lands in a small skid FIFO, so the consumer can stall without losing words
// that are already in flight.
//
// Optional feature macro: SRAM_FIFO_CTRL_ERR_EN
//   defined     : err_o is a sticky protocol/consistency error flag
//   not defined : err_o is tied low and no checking logic is built
//
// Parameters
//   WIDTH    data width (equal to the SRAM word width)
//   DEPTH    SRAM entries, power of two >= 2
//   LATENCY  SRAM ren_i -> vld_o latency in cycles, >= 1
//   ADDR_W   SRAM address width
//   SKID_D   skid buffer entries, which is also the number of read credits
//
// Ports
//   clk_i         clock, rising edge
//   rst_ni        asynchronous reset, active low
//   in_valid_i    producer has data
//   in_data_i     producer data
//   in_ready_o    controller accepts (push = in_valid_i & in_ready_o)
//   out_valid_o   head of output stream valid
//   out_data_o    head of output stream data
//   out_ready_i   consumer accepts (pop = out_valid_o & out_ready_i)
//   sram_wen_o    SRAM write enable
//   sram_waddr_o  SRAM write address
//   sram_wdata_o  SRAM write data
//   sram_ren_o    SRAM read enable
//   sram_raddr_o  SRAM read address
//   sram_rdata_i  SRAM read data
//   sram_rvld_i   SRAM read data valid
//   level_o       total held entries (SRAM + in flight + skid), registered
//   err_o         sticky protocol error
// ---------------------------------------------------------------------------
module sram_fifo_ctrl #(
    parameter int WIDTH   = 8,
    parameter int DEPTH   = 8,
    parameter int LATENCY = 5,
    parameter int ADDR_W  = $clog2(DEPTH),
    parameter int SKID_D  = LATENCY + 1
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                in_valid_i,
    input  logic [WIDTH-1:0]                    in_data_i,
    output logic                                in_ready_o,
    output logic                                out_valid_o,
    output logic [WIDTH-1:0]                    out_data_o,
    input  logic                                out_ready_i,
    output logic                                sram_wen_o,
    output logic [ADDR_W-1:0]                   sram_waddr_o,
    output logic [WIDTH-1:0]                    sram_wdata_o,
    output logic                                sram_ren_o,
    output logic [ADDR_W-1:0]                   sram_raddr_o,
    input  logic [WIDTH-1:0]                    sram_rdata_i,
    input  logic                                sram_rvld_i,
    output logic [$clog2(DEPTH+SKID_D+1)-1:0]   level_o,
    output logic                                err_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int CR_W  = $clog2(SKID_D + 1);
    localparam int SUM_W = CR_W + 1;
    localparam int SP_W  = (SKID_D > 1) ? $clog2(SKID_D) : 1;
    localparam int LVL_W = $clog2(DEPTH + SKID_D + 1);

    // Skid pointers wrap at SKID_D, which need not be a power of two.
    function automatic logic [SP_W-1:0] skid_ptr_inc(input logic [SP_W-1:0] p);
        if (p == SP_W'(SKID_D - 1)) begin
            return '0;
        end
        return p + SP_W'(1);
    endfunction

    // SRAM pointers rely on DEPTH being a power of two for natural wrap.
    function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
        return a + ADDR_W'(1);
    endfunction

    // Control state
    logic [ADDR_W-1:0] wr_ptr,   wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr,   rd_ptr_d;
    logic [CNT_W-1:0]  sram_cnt, sram_cnt_d;
    logic [CR_W-1:0]   inflight, inflight_d;
    logic [CR_W-1:0]   skid_cnt, skid_cnt_d;
    logic [SP_W-1:0]   skid_wp,  skid_wp_d;
    logic [SP_W-1:0]   skid_rp,  skid_rp_d;
    logic [LVL_W-1:0]  level_q,  level_d;

    // Skid storage (data only, never reset)
    logic [WIDTH-1:0]  skid_mem [SKID_D];

    logic push;
    logic pop;
    logic ren;
    logic skid_empty;
    logic skid_wr;
    logic skid_rd;
    logic credit_ok;

    // -----------------------------------------------------------------------
    // Stage p0: combinational handshakes and SRAM request generation
    // -----------------------------------------------------------------------
    assign in_ready_o = (sram_cnt < CNT_W'(DEPTH));
    assign push       = in_valid_i & in_ready_o;

    // Every word that is in flight or parked in the skid consumes a credit,
    // so a read is only issued when the skid is guaranteed to have room for
    // its data when it returns.
    assign credit_ok  = (SUM_W'(inflight) + SUM_W'(skid_cnt)) < SUM_W'(SKID_D);
    assign ren        = (sram_cnt != '0) & credit_ok;

    assign sram_wen_o   = push;
    assign sram_waddr_o = wr_ptr;
    assign sram_wdata_o = in_data_i;
    assign sram_ren_o   = ren;
    assign sram_raddr_o = rd_ptr;

    // When the skid is empty, returning SRAM data is presented directly so
    // a word is visible on the cycle it arrives and a continuously popping
    // consumer never sees a bubble. If the consumer stalls, the word is
    // captured into the skid and held from there on the following cycles.
    assign skid_empty  = (skid_cnt == '0);
    assign out_valid_o = ~skid_empty | sram_rvld_i;
    assign out_data_o  = skid_empty ? sram_rdata_i : skid_mem[skid_rp];
    assign pop         = out_valid_o & out_ready_i;

    assign skid_wr = sram_rvld_i & ~(pop & skid_empty);
    assign skid_rd = pop & ~skid_empty;

    always_comb begin
        wr_ptr_d   = push ? addr_inc(wr_ptr) : wr_ptr;
        rd_ptr_d   = ren  ? addr_inc(rd_ptr) : rd_ptr;
        sram_cnt_d = sram_cnt + CNT_W'(push) - CNT_W'(ren);
        inflight_d = inflight + CR_W'(ren) - CR_W'(sram_rvld_i);
        skid_cnt_d = skid_cnt + CR_W'(skid_wr) - CR_W'(skid_rd);
        skid_wp_d  = skid_wr ? skid_ptr_inc(skid_wp) : skid_wp;
        skid_rp_d  = skid_rd ? skid_ptr_inc(skid_rp) : skid_rp;
        level_d    = LVL_W'(sram_cnt_d) + LVL_W'(inflight_d) + LVL_W'(skid_cnt_d);
    end

    // -----------------------------------------------------------------------
    // Stage p1: registered control state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            sram_cnt <= '0;
            inflight <= '0;
            skid_cnt <= '0;
            skid_wp  <= '0;
            skid_rp  <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr   <= wr_ptr_d;
            rd_ptr   <= rd_ptr_d;
            sram_cnt <= sram_cnt_d;
            inflight <= inflight_d;
            skid_cnt <= skid_cnt_d;
            skid_wp  <= skid_wp_d;
            skid_rp  <= skid_rp_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (skid_wr) begin
            skid_mem[skid_wp] <= sram_rdata_i;
        end
    end

    assign level_o = level_q;

`ifdef SRAM_FIFO_CTRL_ERR_EN
    // -----------------------------------------------------------------------
    // Stage p1: protocol checking
    // -----------------------------------------------------------------------
    logic             stall_p1;
    logic [WIDTH-1:0] data_p1;
    logic             err_q;
    logic             err_set;

    // A stalled producer must keep valid high and data unchanged. Data from
    // the SRAM must match an outstanding read and find room in the skid.
    always_comb begin
        err_set = 1'b0;
        if (sram_rvld_i && (inflight == '0)) begin
            err_set = 1'b1;
        end
        if (sram_rvld_i && (skid_cnt == CR_W'(SKID_D))) begin
            err_set = 1'b1;
        end
        if (stall_p1 && (!in_valid_i || (in_data_i != data_p1))) begin
            err_set = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_p1 <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            stall_p1 <= in_valid_i & ~in_ready_o;
            err_q    <= err_q | err_set;
        end
    end

    always_ff @(posedge clk_i) begin
        data_p1 <= in_data_i;
    end

    assign err_o = err_q;
`else
    assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_fifo_ctrl
//
// Directed bench for sram_fifo_ctrl with a behavioural dual-port SRAM of
// fixed read latency attached. Inputs are driven just after the rising edge;
// outputs are examined on the falling edge.
// ---------------------------------------------------------------------------
module tb_sram_fifo_ctrl;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 8;
    localparam int LATENCY = 5;
    localparam int ADDR_W  = 3;
    localparam int SKID_D  = LATENCY + 1;
    localparam int LVL_W   = $clog2(DEPTH + SKID_D + 1);

`ifdef SRAM_FIFO_CTRL_ERR_EN
    localparam logic ERR_EXP = 1'b1;
`else
    localparam logic ERR_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic              out_ready;
    logic              sram_wen;
    logic [ADDR_W-1:0] sram_waddr;
    logic [WIDTH-1:0]  sram_wdata;
    logic              sram_ren;
    logic [ADDR_W-1:0] sram_raddr;
    logic [WIDTH-1:0]  sram_rdata;
    logic              sram_rvld;
    logic [LVL_W-1:0]  level;
    logic              err;
    logic              force_vld;

    always #5 clk = ~clk;

    sram_fifo_ctrl #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .LATENCY (LATENCY),
        .ADDR_W  (ADDR_W),
        .SKID_D  (SKID_D)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_data_i    (in_data),
        .in_ready_o   (in_ready),
        .out_valid_o  (out_valid),
        .out_data_o   (out_data),
        .out_ready_i  (out_ready),
        .sram_wen_o   (sram_wen),
        .sram_waddr_o (sram_waddr),
        .sram_wdata_o (sram_wdata),
        .sram_ren_o   (sram_ren),
        .sram_raddr_o (sram_raddr),
        .sram_rdata_i (sram_rdata),
        .sram_rvld_i  (sram_rvld),
        .level_o      (level),
        .err_o        (err)
    );

    // Behavioural SRAM: read issued in cycle c returns data in cycle c+LATENCY
    logic [WIDTH-1:0]   mem   [DEPTH];
    logic [LATENCY-1:0] vpipe;
    logic [WIDTH-1:0]   dpipe [LATENCY];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vpipe <= '0;
        else        vpipe <= {vpipe[LATENCY-2:0], sram_ren};
    end

    always_ff @(posedge clk) begin
        if (sram_wen) mem[sram_waddr] <= sram_wdata;
        dpipe[0] <= mem[sram_raddr];
        for (int i = 1; i < LATENCY; i++) dpipe[i] <= dpipe[i-1];
    end

    assign sram_rvld  = vpipe[LATENCY-1] | force_vld;
    assign sram_rdata = dpipe[LATENCY-1];

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    // Random-phase scoreboard state
    logic [WIDTH-1:0] sb [$];
    logic             hold   = 1'b0;
    logic             pstall = 1'b0;
    logic [WIDTH-1:0] pdata  = '0;

    task automatic rand_cycle(input logic drain);
        if (!hold) begin
            in_valid = drain ? 1'b0 : 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
        end
        out_ready = drain ? 1'b1 : 1'($urandom_range(0, 1));
        settle();
        chk("rand_level", 32'(level), 32'(sb.size()));
        if (pstall) begin
            chk("rand_hold_vld", 32'(out_valid), 32'd1);
            chk("rand_hold_data", 32'(out_data), 32'(pdata));
        end
        if (out_valid && out_ready) begin
            chk("rand_pop_avail", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) chk("rand_data", 32'(out_data), 32'(sb.pop_front()));
        end
        if (in_valid && in_ready) sb.push_back(in_data);
        hold   = in_valid && !in_ready;
        pstall = out_valid && !out_ready;
        pdata  = out_data;
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        int cyc;
        int n_in;
        int n_out;
        int n_rd;
        int bubbles;
        int wwr;
        int rwr;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        force_vld = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        settle();
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_wen", 32'(sram_wen), 32'd0);
        chk("rst_ren", 32'(sram_ren), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;

        // Single word latency: push at t=0, read at t=1, data at t=6
        in_valid  = 1'b1;
        in_data   = 8'hA5;
        out_ready = 1'b1;
        settle();
        chk("t1_wen", 32'(sram_wen), 32'd1);
        chk("t1_waddr", 32'(sram_waddr), 32'd0);
        chk("t1_wdata", 32'(sram_wdata), 32'hA5);
        tick();
        in_valid = 1'b0;
        settle();
        chk("t1_ren", 32'(sram_ren), 32'd1);
        chk("t1_raddr", 32'(sram_raddr), 32'd0);
        chk("t1_level1", 32'(level), 32'd1);
        tick();
        for (int c = 2; c < 6; c++) begin
            settle();
            chk("t1_no_vld", 32'(out_valid), 32'd0);
            tick();
        end
        settle();
        chk("t1_vld", 32'(out_valid), 32'd1);
        chk("t1_data", 32'(out_data), 32'hA5);
        tick();
        settle();
        chk("t1_level0", 32'(level), 32'd0);
        chk("t1_vld_gone", 32'(out_valid), 32'd0);
        tick();

        // Fill with consumer stalled: 14 words fit, the 15th stalls
        out_ready = 1'b0;
        cnt = 0;
        cyc = 0;
        while (cnt < 14 && cyc < 40) begin
            in_valid = 1'b1;
            in_data  = 8'(cnt);
            settle();
            if (in_ready) cnt++;
            tick();
            cyc++;
        end
        chk("fill_cycles", 32'(cyc), 32'd14);
        in_data = 8'h0E;
        settle();
        chk("fill_stall", 32'(in_ready), 32'd0);
        tick();
        repeat (4) tick();
        settle();
        chk("fill_level", 32'(level), 32'd14);
        chk("fill_in_ready", 32'(in_ready), 32'd0);
        chk("fill_out_vld", 32'(out_valid), 32'd1);
        chk("fill_head", 32'(out_data), 32'h00);
        chk("fill_no_ren", 32'(sram_ren), 32'd0);
        tick();

        // Drain from full; the stalled 0x0E is accepted once space frees
        out_ready = 1'b1;
        for (int k = 0; k < 15; k++) begin
            settle();
            chk("drain_vld", 32'(out_valid), 32'd1);
            chk("drain_data", 32'(out_data), 32'(k));
            if (k == 0) chk("drain_ren0", 32'(sram_ren), 32'd0);
            if (k == 1) begin
                chk("drain_ren1", 32'(sram_ren), 32'd1);
                chk("drain_rdy1", 32'(in_ready), 32'd0);
            end
            if (k == 2) chk("drain_rdy2", 32'(in_ready), 32'd1);
            tick();
            if (k == 2) in_valid = 1'b0;
        end
        settle();
        chk("drain_empty", 32'(out_valid), 32'd0);
        chk("drain_level", 32'(level), 32'd0);
        tick();

        // Streaming: 100 words back to back
        n_in = 0; n_out = 0; n_rd = 0; bubbles = 0; wwr = 0; rwr = 0;
        out_ready = 1'b1;
        for (int c = 0; c < 130; c++) begin
            in_valid = (n_in < 100);
            in_data  = 8'(n_in);
            settle();
            if (out_valid) begin
                chk("stream_data", 32'(out_data), 32'(8'(n_out)));
                n_out++;
            end else if (n_out > 0 && n_out < 100) begin
                bubbles++;
            end
            if (sram_ren) begin
                if (sram_raddr == '0 && n_rd > 0) rwr++;
                n_rd++;
            end
            if (in_valid && in_ready) begin
                if (sram_waddr == '0 && n_in > 0) wwr++;
                n_in++;
            end
            tick();
        end
        in_valid = 1'b0;
        chk("stream_n_in", 32'(n_in), 32'd100);
        chk("stream_n_out", 32'(n_out), 32'd100);
        chk("stream_bubbles", 32'(bubbles), 32'd0);
        chk("stream_wwrap", 32'(wwr), 32'd12);
        chk("stream_rwrap", 32'(rwr), 32'd12);

        // Random traffic against the scoreboard, then drain
        for (int c = 0; c < 10000; c++) rand_cycle(1'b0);
        for (int c = 0; c < 60; c++) rand_cycle(1'b1);
        in_valid = 1'b0;
        settle();
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);
        chk("rand_end_level", 32'(level), 32'd0);
        chk("rand_err", 32'(err), 32'd0);
        tick();

        // Reset in the middle of traffic
        out_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(8'h40 + i);
            tick();
        end
        in_valid = 1'b0;
        settle();
        chk("mid_level", 32'(level), 32'd8);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_level", 32'(level), 32'd0);
        chk("mid_rst_vld", 32'(out_valid), 32'd0);
        chk("mid_rst_rdy", 32'(in_ready), 32'd1);
        chk("mid_rst_ren", 32'(sram_ren), 32'd0);
        tick();
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            settle();
            chk("post_rst_no_vld", 32'(out_valid), 32'd0);
            tick();
        end
        in_valid = 1'b1;
        in_data  = 8'h3C;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        settle();
        chk("post_rst_vld", 32'(out_valid), 32'd1);
        chk("post_rst_data", 32'(out_data), 32'h3C);
        tick();

        // Spurious read-valid with nothing in flight
        out_ready = 1'b0;
        force_vld = 1'b1;
        settle();
        chk("err_before", 32'(err), 32'd0);
        tick();
        force_vld = 1'b0;
        settle();
        chk("err_set", 32'(err), 32'(ERR_EXP));
        repeat (3) tick();
        settle();
        chk("err_sticky", 32'(err), 32'(ERR_EXP));
        tick();
        rst_n = 1'b0;
        #1;
        chk("err_cleared", 32'(err), 32'd0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
